// File: rtl/asic_clkdiv_if.sv
// Control and divided-clock bundle for asic_clkdiv.
// The master drives run/ratio; the slave returns the clocks and strobes.
interface asic_clkdiv_if #(
  parameter int DW = 8
);
  logic          en;
  logic [DW-1:0] divcfg;
  logic          clkout;
  logic          clkout90;
  logic          rise;
  logic          fall;
  logic          busy;

  modport master (
    output en, divcfg,
    input  clkout, clkout90, rise, fall, busy
  );

  modport slave (
    input  en, divcfg,
    output clkout, clkout90, rise, fall, busy
  );
endinterface

// File: rtl/asic_clkdiv.sv
// Programmable clock divider with quadrature output and edge strobes.
// Ratio and run request are sampled only in IDLE or at period boundaries.
module asic_clkdiv #(
  parameter int    DW   = 8,
  parameter string PROP = "DEFAULT"
) (
  input logic         clk,
  input logic         nreset,
  asic_clkdiv_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] ract_q, ract_d;
  logic [DW-1:0] eff_cfg;
  logic [DW-1:0] h_d, q_d;
  logic [DW:0]   qh_d;
  logic          last;
  logic          run_d;
  logic          clkout_q, clkout_d;
  logic          clk90_q, clk90_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          unused_prop;

  assign unused_prop = (PROP != "");

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ract_d  = ract_q;
    eff_cfg = (bus.divcfg < DW'(2)) ? DW'(2)
                                    : bus.divcfg;
    last    = (cnt_q == ract_q - DW'(1));
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = RUN;
          cnt_d   = '0;
          ract_d  = eff_cfg;
        end
      end
      RUN: begin
        if (!last) begin
          cnt_d = cnt_q + DW'(1);
        end else begin
          cnt_d = '0;
          if (bus.en) ract_d  = eff_cfg;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state so they align with cnt.
    h_d      = ract_d >> 1;
    q_d      = ract_d >> 2;
    qh_d     = {1'b0, q_d} + {1'b0, h_d};
    run_d    = (state_d == RUN);
    clkout_d = run_d && (cnt_d < h_d);
    clk90_d  = run_d && (cnt_d >= q_d)
             && ({1'b0, cnt_d} < qh_d);
    rise_d   = run_d && (cnt_d == '0);
    fall_d   = run_d && (cnt_d == h_d);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ract_q   <= DW'(2);
      clkout_q <= 1'b0;
      clk90_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ract_q   <= ract_d;
      clkout_q <= clkout_d;
      clk90_q  <= clk90_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign bus.clkout   = clkout_q;
  assign bus.clkout90 = clk90_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.busy     = (state_q == RUN);

endmodule

// File: tb/tb_asic_clkdiv.sv
// Self-checking bench for asic_clkdiv.
// A period-level waveform queue predicts every output cycle.
module tb_asic_clkdiv;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic nreset = 1'b0;

  asic_clkdiv_if #(.DW(DW)) bus();

  asic_clkdiv #(
    .DW(DW),
    .PROP("DEFAULT")
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [4:0] q[$];
  logic [4:0] exp_v = '0;

  function automatic int eff(int d);
    return (d < 2) ? 2 : d;
  endfunction

  // One whole period: {clkout, clkout90, rise, fall, busy} per cycle.
  task automatic push_period(int r);
    int h;
    int o;
    h = r / 2;
    o = r / 4;
    for (int k = 0; k < r; k++) begin
      q.push_back({(k < h), (k >= o && k < o + h),
                   (k == 0), (k == h), 1'b1});
    end
  endtask

  task automatic check(string tag);
    logic [4:0] obs;
    obs = {bus.clkout, bus.clkout90, bus.rise,
           bus.fall, bus.busy};
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s obs=%b exp=%b t=%0t",
             tag, obs, exp_v, $time);
    end
  endtask

  task automatic step(bit e, int d, string tag);
    bus.en     = e;
    bus.divcfg = DW'(d);
    @(posedge clk);
    if (q.size() == 0 && e) push_period(eff(d));
    exp_v = (q.size() != 0) ? q.pop_front() : 5'b0;
    #1 check(tag);
  endtask

  task automatic do_reset(string tag);
    #2 nreset = 1'b0;
    q.delete();
    exp_v = '0;
    #1 check(tag);
    @(posedge clk);
    #1 check({tag, "_hold"});
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic idle_out(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, "drain");
  endtask

  initial begin
    bus.en     = 1'b0;
    bus.divcfg = '0;
    #2 check("reset");
    #10 nreset = 1'b1;

    step(1'b0, 4, "idle");
    step(1'b0, 4, "idle");

    for (int i = 0; i < 12; i++) step(1'b1, 4, "r4");
    idle_out(4);
    for (int i = 0; i < 15; i++) step(1'b1, 5, "r5");
    idle_out(5);
    for (int i = 0; i < 8; i++) step(1'b1, 0, "r0");
    idle_out(2);
    for (int i = 0; i < 8; i++) step(1'b1, 1, "r1");
    idle_out(2);
    for (int i = 0; i < 7; i++) step(1'b1, 3, "r3");
    idle_out(3);

    step(1'b1, 4, "chg4");
    for (int i = 0; i < 16; i++) step(1'b1, 6, "chg6");
    idle_out(6);

    step(1'b1, 4, "drop4");
    for (int i = 0; i < 7; i++) step(1'b0, 4, "drop");

    step(1'b1, 4, "tog");
    step(1'b0, 4, "tog");
    step(1'b1, 4, "tog");
    for (int i = 0; i < 6; i++) step(1'b0, 4, "tog");

    step(1'b1, 6, "arst");
    step(1'b1, 6, "arst");
    do_reset("arst_hi");
    for (int i = 0; i < 8; i++) step(1'b1, 4, "rstrt");
    idle_out(4);

    step(1'b1, 255, "rmax");
    for (int i = 0; i < 260; i++) step(1'b0, 255, "rmax");

    for (int i = 0; i < 800; i++) begin
      bit e;
      int d;
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 255);
      else d = $urandom_range(0, 9);
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      else step(e, d, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
